// File: rtl/ws2811_pkg.sv
// Shared timing constants, state encoding and ns-to-cycle conversion
// for the WS2811 receive path.
package ws2811_pkg;

    localparam int unsigned T0H_NS    = 500;
    localparam int unsigned T1H_NS    = 1200;
    localparam int unsigned BIT_NS    = 2500;
    localparam int unsigned RESET_NS  = 50_000;
    localparam int unsigned WORD_BITS = 24;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        RX_HIGH,
        RX_LOW
    } rx_state_e;

    function automatic int unsigned cyc(input int unsigned ns,
                                        input int unsigned clk_hz);
        return ns * (clk_hz / 1_000_000) / 1000;
    endfunction

endpackage

// File: rtl/ws2811_rx_sync.sv
// Two-flop synchroniser for the serial line with registered
// rise/fall strobes aligned to the delayed level.
module ws2811_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, level_q, rise_q, fall_q;
    logic meta_d, sync_d, level_d, rise_d, fall_d;

    always_comb begin
        meta_d  = rx_i;
        sync_d  = meta_q;
        level_d = sync_q;
        rise_d  = sync_q & ~level_q;
        fall_d  = ~sync_q & level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ws2811_receiver.sv
// WS2811 pulse-width decoder: measures high/low durations and assembles
// 24-bit MSB-first words, flagging latch (frame end) and timing faults.
module ws2811_receiver
    import ws2811_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED  = 50_000_000,
    parameter int unsigned THRESHOLD_NS = 850,
    parameter int unsigned MIN_HIGH_NS  = 200,
    parameter int unsigned MAX_HIGH_NS  = 2000,
    parameter int unsigned RESET_NS     = 50_000
) (
    input  logic        clkIN,
    input  logic        nResetIN,
    input  logic        rxIN,
    output logic [23:0] dataOUT,
    output logic        validOUT,
    output logic        latchOUT,
    output logic        errorOUT,
    output logic        busyOUT
);

    localparam int unsigned THR_CYC = cyc(THRESHOLD_NS, CLOCK_SPEED);
    localparam int unsigned MIN_CYC = cyc(MIN_HIGH_NS, CLOCK_SPEED);
    localparam int unsigned MAX_CYC = cyc(MAX_HIGH_NS, CLOCK_SPEED);
    localparam int unsigned RST_CYC = cyc(RESET_NS, CLOCK_SPEED);
    localparam int          CW      = $clog2(RST_CYC + 1);

    localparam logic [CW-1:0] THR_C = CW'(THR_CYC);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_CYC);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_CYC);
    localparam logic [CW-1:0] RST_C = CW'(RST_CYC);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic level, rise, fall;

    ws2811_rx_sync u_sync (
        .clk    (clkIN),
        .rst_n  (nResetIN),
        .rx_i   (rxIN),
        .level_o(level),
        .rise_o (rise),
        .fall_o (fall)
    );

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [4:0]    bits_q, bits_d;
    logic [22:0]   shift_q, shift_d;
    logic          word_q, word_d;
    logic [23:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          latch_q, latch_d;
    logic          error_q, error_d;
    logic          busy_q, busy_d;
    logic          bit_v;

    always_comb begin
        state_d = state_q;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_inc;
        bits_d  = bits_q;
        shift_d = shift_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = 1'b0;
        latch_d = 1'b0;
        error_d = 1'b0;
        bit_v   = (cnt_q >= THR_C);
        unique case (state_q)
            SYNC: begin
                if (level) begin
                    cnt_d = '0;
                end else if (cnt_q >= RST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = RX_HIGH;
                    cnt_d   = ONE_C;
                end
            end
            RX_HIGH: begin
                // Stuck-high is caught while still high, one cycle
                // before the count would pass the limit.
                if (!fall && cnt_q >= MAX_C) begin
                    error_d = 1'b1;
                    state_d = SYNC;
                    cnt_d   = '0;
                    bits_d  = '0;
                    word_d  = 1'b0;
                end else if (fall && cnt_q < MIN_C) begin
                    error_d = 1'b1;
                    state_d = SYNC;
                    cnt_d   = '0;
                    bits_d  = '0;
                    word_d  = 1'b0;
                end else if (fall) begin
                    state_d = RX_LOW;
                    cnt_d   = ONE_C;
                    shift_d = {shift_q[21:0], bit_v};
                    if (bits_q == 5'd23) begin
                        data_d  = {shift_q, bit_v};
                        valid_d = 1'b1;
                        bits_d  = '0;
                        word_d  = 1'b1;
                    end else begin
                        bits_d = bits_q + 5'd1;
                    end
                end
            end
            RX_LOW: begin
                if (rise) begin
                    state_d = RX_HIGH;
                    cnt_d   = ONE_C;
                end else if (cnt_q >= RST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    bits_d  = '0;
                    word_d  = 1'b0;
                    if (bits_q != 5'd0) begin
                        error_d = 1'b1;
                    end else if (word_q) begin
                        latch_d = 1'b1;
                    end
                end
            end
        endcase
        busy_d = (state_d == RX_HIGH) || (state_d == RX_LOW);
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            word_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            latch_q <= latch_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign dataOUT  = data_q;
    assign validOUT = valid_q;
    assign latchOUT = latch_q;
    assign errorOUT = error_q;
    assign busyOUT  = busy_q;

endmodule
